// File: rtl/amp_ctrl_pkg.sv
// Shared types and default timing constants for the class-D amp supervisor.
package amp_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_OFF           = 4'd0,
        ST_ENABLE_WAIT   = 4'd1,
        ST_CONFIG        = 4'd2,
        ST_RUN           = 4'd3,
        ST_FAULT_MUTE    = 4'd4,
        ST_FAULT_DISABLE = 4'd5,
        ST_SHUTDOWN_MUTE = 4'd6,
        ST_LOCKOUT       = 4'd7
    } amp_state_t;

    localparam int DEF_EN_WAIT_CYC     = 1024;
    localparam int DEF_CFG_TIMEOUT_CYC = 4096;
    localparam int DEF_MUTE_CYC        = 64;
    localparam int DEF_BACKOFF_CYC     = 8192;
    localparam int DEF_STABLE_CYC      = 65536;
    localparam int DEF_DEBOUNCE_CYC    = 4;
    localparam int DEF_MAX_RETRY       = 3;
    localparam int DEF_RETRY_W         = 2;
    localparam int DEF_CNT_W           = 20;

endpackage

// File: rtl/amp_fault_supervisor_if.sv
// Amp-side pins, system control and config handshake of the amp supervisor.
interface amp_fault_supervisor_if #(
    parameter int RETRY_W = amp_ctrl_pkg::DEF_RETRY_W
);
    logic               amp_enable_in;
    logic               audio_locked_in;
    logic               nerror_in;
    logic               cfg_done_in;
    logic               nenable_out;
    logic               nmute_out;
    logic               send_config_out;
    logic               fault_latched_out;
    logic [RETRY_W-1:0] retry_count_out;

    modport master (
        output amp_enable_in, audio_locked_in, nerror_in, cfg_done_in,
        input  nenable_out, nmute_out, send_config_out, fault_latched_out, retry_count_out
    );

    modport slave (
        input  amp_enable_in, audio_locked_in, nerror_in, cfg_done_in,
        output nenable_out, nmute_out, send_config_out, fault_latched_out, retry_count_out
    );
endinterface

// File: rtl/amp_delay_counter.sv
// Loadable down-counter; loading N-1 gives exactly N cycles until expired.
module amp_delay_counter #(
    parameter int CNT_W = 20
) (
    input  logic             clk_in,
    input  logic             resetb,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] value,
    output logic             expired
);

    always_ff @(posedge clk_in or negedge resetb) begin
        if (!resetb) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (value != '0) begin
            value <= value - CNT_W'(1);
        end
    end

    assign expired = (value == '0);

endmodule

// File: rtl/amp_fault_supervisor.sv
// Class-D amp bring-up sequencer with debounced fault recovery and lockout.
//
// state            | meaning
// OFF              | amp disabled and muted, waiting for enable request
// ENABLE_WAIT      | amp enabled, muted, settling
// CONFIG           | config sender requested, waiting for done or timeout
// RUN              | amp unmuted while audio is locked
// FAULT_MUTE       | muting after a fault in RUN
// FAULT_DISABLE    | amp disabled, backing off before a retry
// SHUTDOWN_MUTE    | muting before a requested shutdown
// LOCKOUT          | retries exhausted, held off until enable drops
module amp_fault_supervisor
    import amp_ctrl_pkg::*;
#(
    parameter int EN_WAIT_CYC     = DEF_EN_WAIT_CYC,
    parameter int CFG_TIMEOUT_CYC = DEF_CFG_TIMEOUT_CYC,
    parameter int MUTE_CYC        = DEF_MUTE_CYC,
    parameter int BACKOFF_CYC     = DEF_BACKOFF_CYC,
    parameter int STABLE_CYC      = DEF_STABLE_CYC,
    parameter int DEBOUNCE_CYC    = DEF_DEBOUNCE_CYC,
    parameter int MAX_RETRY       = DEF_MAX_RETRY,
    parameter int RETRY_W         = DEF_RETRY_W,
    parameter int CNT_W           = DEF_CNT_W
) (
    input logic                   clk_in,
    input logic                   resetb,
    amp_fault_supervisor_if.slave amp_if
);

    localparam int DEB_W = $clog2(DEBOUNCE_CYC + 1);

    logic             nerror_s1;
    logic             nerror_s2;
    logic [DEB_W-1:0] deb_cnt;
    logic             fault;

    amp_state_t       state_q;
    amp_state_t       state_nxt;
    amp_state_t       fault_dest;
    logic [RETRY_W-1:0] retry_q;
    logic [RETRY_W-1:0] retry_nxt;

    logic nenable_q,  nenable_nxt;
    logic nmute_q,    nmute_nxt;
    logic send_cfg_q, send_cfg_nxt;
    logic latched_q,  latched_nxt;

    logic             dly_load;
    logic [CNT_W-1:0] dly_load_val;
    logic [CNT_W-1:0] dly_value;
    logic             dly_expired;
    logic             stable_load;
    logic [CNT_W-1:0] stable_value;
    logic             stable_expired;
    logic             unused_cnt_bits;

    // The counter holds at the last-but-one low sample so a held-low pin keeps fault asserted.
    always_ff @(posedge clk_in or negedge resetb) begin
        if (!resetb) begin
            nerror_s1 <= 1'b1;
            nerror_s2 <= 1'b1;
            deb_cnt   <= '0;
        end else begin
            nerror_s1 <= amp_if.nerror_in;
            nerror_s2 <= nerror_s1;
            if (nerror_s2) begin
                deb_cnt <= '0;
            end else if (deb_cnt != DEB_W'(DEBOUNCE_CYC - 1)) begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end
    end

    assign fault = !nerror_s2 && (deb_cnt == DEB_W'(DEBOUNCE_CYC - 1));

    amp_delay_counter #(.CNT_W(CNT_W)) u_dly_cnt (
        .clk_in   (clk_in),
        .resetb   (resetb),
        .load     (dly_load),
        .load_val (dly_load_val),
        .value    (dly_value),
        .expired  (dly_expired)
    );

    amp_delay_counter #(.CNT_W(CNT_W)) u_stable_cnt (
        .clk_in   (clk_in),
        .resetb   (resetb),
        .load     (stable_load),
        .load_val (CNT_W'(STABLE_CYC - 1)),
        .value    (stable_value),
        .expired  (stable_expired)
    );

    assign unused_cnt_bits = ^{dly_value, stable_value};

    always_ff @(posedge clk_in or negedge resetb) begin
        if (!resetb) begin
            state_q    <= ST_OFF;
            retry_q    <= '0;
            nenable_q  <= 1'b1;
            nmute_q    <= 1'b0;
            send_cfg_q <= 1'b0;
            latched_q  <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            retry_q    <= retry_nxt;
            nenable_q  <= nenable_nxt;
            nmute_q    <= nmute_nxt;
            send_cfg_q <= send_cfg_nxt;
            latched_q  <= latched_nxt;
        end
    end

    // An exhausted retry budget redirects the disable step straight into LOCKOUT.
    assign fault_dest = (retry_q == RETRY_W'(MAX_RETRY)) ? ST_LOCKOUT : ST_FAULT_DISABLE;

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_OFF: begin
                if (amp_if.amp_enable_in) state_nxt = ST_ENABLE_WAIT;
            end
            ST_ENABLE_WAIT: begin
                if (!amp_if.amp_enable_in) state_nxt = ST_OFF;
                else if (fault)            state_nxt = fault_dest;
                else if (dly_expired)      state_nxt = ST_CONFIG;
            end
            ST_CONFIG: begin
                if (!amp_if.amp_enable_in)   state_nxt = ST_OFF;
                else if (fault)              state_nxt = fault_dest;
                else if (amp_if.cfg_done_in) state_nxt = ST_RUN;
                else if (dly_expired)        state_nxt = fault_dest;
            end
            ST_RUN: begin
                if (!amp_if.amp_enable_in) state_nxt = ST_SHUTDOWN_MUTE;
                else if (fault)            state_nxt = ST_FAULT_MUTE;
            end
            ST_FAULT_MUTE: begin
                if (!amp_if.amp_enable_in) state_nxt = ST_OFF;
                else if (dly_expired)      state_nxt = fault_dest;
            end
            ST_FAULT_DISABLE: begin
                if (!amp_if.amp_enable_in) state_nxt = ST_OFF;
                else if (dly_expired)      state_nxt = ST_ENABLE_WAIT;
            end
            ST_SHUTDOWN_MUTE: begin
                if (dly_expired) state_nxt = ST_OFF;
            end
            ST_LOCKOUT: begin
                if (!amp_if.amp_enable_in) state_nxt = ST_OFF;
            end
            default: state_nxt = ST_OFF;
        endcase
    end

    assign dly_load    = (state_nxt != state_q);
    assign stable_load = (state_nxt == ST_RUN) && (state_q != ST_RUN);

    always_comb begin
        dly_load_val = '0;
        case (state_nxt)
            ST_ENABLE_WAIT:                  dly_load_val = CNT_W'(EN_WAIT_CYC - 1);
            ST_CONFIG:                       dly_load_val = CNT_W'(CFG_TIMEOUT_CYC - 1);
            ST_FAULT_MUTE, ST_SHUTDOWN_MUTE: dly_load_val = CNT_W'(MUTE_CYC - 1);
            ST_FAULT_DISABLE:                dly_load_val = (CNT_W'(BACKOFF_CYC) << retry_q) - CNT_W'(1);
            default:                         dly_load_val = '0;
        endcase
    end

    always_comb begin
        nenable_nxt  = 1'b1;
        nmute_nxt    = 1'b0;
        send_cfg_nxt = 1'b0;
        latched_nxt  = 1'b0;
        retry_nxt    = retry_q;
        case (state_nxt)
            ST_ENABLE_WAIT, ST_FAULT_MUTE, ST_SHUTDOWN_MUTE: nenable_nxt = 1'b0;
            ST_CONFIG: begin
                nenable_nxt  = 1'b0;
                send_cfg_nxt = 1'b1;
            end
            ST_RUN: begin
                nenable_nxt = 1'b0;
                nmute_nxt   = (state_q == ST_RUN) && amp_if.audio_locked_in;
            end
            ST_LOCKOUT: latched_nxt = 1'b1;
            default: ;
        endcase

        if (state_nxt == ST_OFF) begin
            retry_nxt = '0;
        end else if ((state_nxt == ST_FAULT_DISABLE) && (state_q != ST_FAULT_DISABLE)) begin
            retry_nxt = retry_q + RETRY_W'(1);
        end else if ((state_q == ST_RUN) && (state_nxt == ST_RUN) && stable_expired) begin
            retry_nxt = '0;
        end
    end

    assign amp_if.nenable_out       = nenable_q;
    assign amp_if.nmute_out         = nmute_q;
    assign amp_if.send_config_out   = send_cfg_q;
    assign amp_if.fault_latched_out = latched_q;
    assign amp_if.retry_count_out   = retry_q;

endmodule
